multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
Multi-cycle control unit for the RV32I-subset core. It sequences the shared datapath (register file, ALU, sign/immediate extender, unified instruction/data memory port) across FETCH/DECODE/EXECUTE/MEM/WB steps. It drives every mux select and write strobe, including the 3-bit imm_src into the immediate extender. Memory accesses use a req/ready handshake, so the FSM stalls on slow memory.

Parameters:
- OPC_W, 7, opcode field width (instr[6:0]).
- ST_W, 4, state register width.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- instr  in  32  current instruction-register contents. Valid from DECODE onward.
- zero  in  1  ALU zero flag (combinational from the ALU).
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  memory access is a store.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register and OldPC.
- pc_write  out  1  load the PC from the result bus.
- reg_write  out  1  register-file write enable (rd = instr[11:7]).
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero.
- alu_src_b  out  2  ALU B select: 00 = RD2, 01 = ImmExt, 10 = constant 4.
- alu_control  out  3  ALU op: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- result_src  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- imm_src  out  3  extender format: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- illegal  out  1  one-cycle pulse in DECODE for an unsupported opcode.
- state_o  out  4  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11. Encodings 12–15 go to FETCH on the next edge with all strobes 0.
- Reset: the cycle after rst is sampled high, state=FETCH. While rst=1, every output is 0 (including mem_req, pc_write, reg_write, illegal) and state_o=0. Reset mid-instruction abandons the instruction with no partial writes beyond those already clocked.
- Outputs are Moore (decoded from state), with three exceptions that also depend on inputs: FETCH strobes gated by mem_ready, BEQ pc_write, and alu_control/imm_src decoded from instr.
- Any output not listed for a state is 0.
- imm_src is decoded from instr[6:0] in every state:
  - 0000011 / 0010011 → 000
  - 0100011 → 001
  - 1100011 → 010
  - 1101111 → 011
  - 0110111 → 100
  - anything else → 000
- FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10. ir_write=pc_write=mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, add (branch target into ALUOut). Next state by opcode:
  - lw/sw → MEMADR
  - R-type 0110011 → EXECR
  - 0010011 → EXECI
  - beq → BEQ
  - jal → JAL
  - lui → LUI
  - other → FETCH with illegal=1 for this cycle (instruction skipped; PC already advanced).
- MEMADR: alu_src_a=10, alu_src_b=01, add. Goes to MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_req=1, adr_src=1. Holds until mem_ready, then goes to MEMWB.
- MEMWB: result_src=01, reg_write=1. Goes to FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Holds until mem_ready, then goes to FETCH.
- EXECR: alu_src_a=10, alu_src_b=00, funct decode. Goes to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, funct decode. Goes to ALUWB.
- Funct decode by funct3:
  - 000 → add, or sub when R-type and instr[30]=1
  - 010 → slt
  - 110 → or
  - 111 → and
  - others → add
- ALUWB: result_src=00, reg_write=1. Goes to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero. Goes to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1. Goes to ALUWB (writes OldPC+4 to rd).
- LUI: alu_src_a=11, alu_src_b=01, add. Goes to ALUWB.
- Latency with zero wait states: lw 5 cycles; sw, R, I, jal, lui 4 cycles; beq 3 cycles. Each mem_ready=0 cycle adds one cycle.
- mem_req stays high continuously during a stall; the FSM never drops a request before mem_ready.

Test Plan:
- rst high 3 cycles, then low with mem_ready=1 → all outputs 0 during reset. First post-reset cycle is FETCH with mem_req=1, ir_write=pc_write=1, alu_src_b=10.
- instr=0x00A30333 (add x6,x6,x10) → states 0,1,6,8,0. EXECR alu_control=000. ALUWB reg_write=1, result_src=00. The same sequence with instr=0x40A30333 gives alu_control=001.
- instr=0x00452303 (lw), mem_ready low for 2 cycles in MEMREAD → imm_src=000. MEMREAD held 3 cycles with mem_req=1, adr_src=1. MEMWB reg_write=1, result_src=01. Total 7 cycles.
- instr=0x00652223 (sw) → imm_src=001. MEMWRITE has mem_write=1, mem_req=1. reg_write is never 1.
- beq 0x00628463: with zero=1, BEQ pc_write=1, 3 cycles total. With zero=0, pc_write=0.
- jal 0x008000EF → imm_src=011, JAL pc_write=1, then ALUWB reg_write=1. Also: lui 0x12345237 → imm_src=100, alu_src_a=11. Opcode 0x7F → illegal pulses 1 cycle in DECODE, then FETCH. rst asserted in MEMREAD → FETCH, no reg_write.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if
// Groups the control-unit bus: datapath status into the controller
// (instruction register, ALU zero flag, memory ready) and every mux
// select and write strobe the controller drives back into the datapath.
//   master : the controller (drives strobes, reads status)
//   slave  : the datapath/memory side (reads strobes, drives status)
interface multicycle_controller_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;

    logic        mem_req;
    logic        mem_write;
    logic        adr_src;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alu_control;
    logic [1:0]  result_src;
    logic [2:0]  imm_src;
    logic        illegal;
    logic [3:0]  state_o;

    modport master (
        input  instr, zero, mem_ready,
        output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_control, result_src, imm_src,
               illegal, state_o
    );

    modport slave (
        output instr, zero, mem_ready,
        input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_control, result_src, imm_src,
               illegal, state_o
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller
// Multi-cycle control FSM for the RV32I-subset core. Steps the shared
// datapath through FETCH/DECODE/EXECUTE/MEM/WB and stalls on the memory
// req/ready handshake.
// Ports:
//   clk  - core clock, rising edge
//   rst  - synchronous active-high reset; all outputs forced to 0 while high
//   bus  - multicycle_controller_if.master: instr/zero/mem_ready in,
//          mem_req/mem_write/adr_src/ir_write/pc_write/reg_write,
//          alu_src_a/alu_src_b/alu_control/result_src/imm_src,
//          illegal and state_o out
module multicycle_controller #(
    parameter int OPC_W = 7,
    parameter int ST_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);
    localparam logic [ST_W-1:0] S_FETCH    = ST_W'(0);
    localparam logic [ST_W-1:0] S_DECODE   = ST_W'(1);
    localparam logic [ST_W-1:0] S_MEMADR   = ST_W'(2);
    localparam logic [ST_W-1:0] S_MEMREAD  = ST_W'(3);
    localparam logic [ST_W-1:0] S_MEMWB    = ST_W'(4);
    localparam logic [ST_W-1:0] S_MEMWRITE = ST_W'(5);
    localparam logic [ST_W-1:0] S_EXECR    = ST_W'(6);
    localparam logic [ST_W-1:0] S_EXECI    = ST_W'(7);
    localparam logic [ST_W-1:0] S_ALUWB    = ST_W'(8);
    localparam logic [ST_W-1:0] S_BEQ      = ST_W'(9);
    localparam logic [ST_W-1:0] S_JAL      = ST_W'(10);
    localparam logic [ST_W-1:0] S_LUI      = ST_W'(11);

    localparam logic [OPC_W-1:0] OP_LOAD  = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_STORE = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_RTYPE = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_ITYPE = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_BEQ   = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL   = 7'b1101111;
    localparam logic [OPC_W-1:0] OP_LUI   = 7'b0110111;

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  next_state;
    logic [OPC_W-1:0] opcode;
    logic [2:0]       funct3;
    logic [2:0]       funct_op;
    logic [2:0]       imm_dec;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control, imm_src;
    logic       illegal;

    logic unused_instr_bits;

    assign opcode = bus.instr[OPC_W-1:0];
    assign funct3 = bus.instr[14:12];
    assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

    // ALU operation for EXECR/EXECI; instr[30] only selects sub for R-type,
    // because in I-type it is an immediate bit.
    always_comb begin
        funct_op = 3'b000;
        case (funct3)
            3'b000:  funct_op = (opcode == OP_RTYPE && bus.instr[30]) ? 3'b001 : 3'b000;
            3'b010:  funct_op = 3'b101;
            3'b110:  funct_op = 3'b011;
            3'b111:  funct_op = 3'b010;
            default: funct_op = 3'b000;
        endcase
    end

    always_comb begin
        imm_dec = 3'b000;
        case (opcode)
            OP_STORE: imm_dec = 3'b001;
            OP_BEQ:   imm_dec = 3'b010;
            OP_JAL:   imm_dec = 3'b011;
            OP_LUI:   imm_dec = 3'b100;
            default:  imm_dec = 3'b000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BEQ:            next_state = S_BEQ;
                    OP_JAL:            next_state = S_JAL;
                    OP_LUI:            next_state = S_LUI;
                    default:           next_state = S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: next_state = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI,
            S_JAL,
            S_LUI:      next_state = S_ALUWB;
            default:    next_state = S_FETCH;
        endcase
    end

    // Output decode; everything is held at 0 while rst is high, regardless
    // of the state still in the register during that cycle.
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_control = 3'b000;
        result_src  = 2'b00;
        imm_src     = 3'b000;
        illegal     = 1'b0;
        if (!rst) begin
            imm_src = imm_dec;
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = bus.mem_ready;
                    pc_write   = bus.mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    case (opcode)
                        OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
                        OP_BEQ, OP_JAL, OP_LUI: illegal = 1'b0;
                        default:                illegal = 1'b1;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a   = 2'b10;
                    alu_control = funct_op;
                end
                S_EXECI: begin
                    alu_src_a   = 2'b10;
                    alu_src_b   = 2'b01;
                    alu_control = funct_op;
                end
                S_ALUWB: reg_write = 1'b1;
                S_BEQ: begin
                    alu_src_a   = 2'b10;
                    alu_control = 3'b001;
                    pc_write    = bus.zero;
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                S_LUI: begin
                    alu_src_a = 2'b11;
                    alu_src_b = 2'b01;
                end
                default: imm_src = imm_dec;
            endcase
        end
    end

    assign bus.mem_req     = mem_req;
    assign bus.mem_write   = mem_write;
    assign bus.adr_src     = adr_src;
    assign bus.ir_write    = ir_write;
    assign bus.pc_write    = pc_write;
    assign bus.reg_write   = reg_write;
    assign bus.alu_src_a   = alu_src_a;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.alu_control = alu_control;
    assign bus.result_src  = result_src;
    assign bus.imm_src     = imm_src;
    assign bus.illegal     = illegal;
    assign bus.state_o     = rst ? 4'd0 : state;
endmodule
